// File: rtl/serializer_if.sv
`timescale 1ns/1ps
// serializer_if: byte-wide valid/ready input side and serial line status
// outputs of the serializer, bundled so producer and line side share one port.
interface serializer_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       data_out;
    logic       busy;
    logic       frame_done;

    // Producer / observer side (drives bytes, watches the line).
    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  data_out,
        input  busy,
        input  frame_done
    );

    // Serializer side.
    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output data_out,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/serializer.sv
`timescale 1ns/1ps
// serializer: collects four accepted bytes into a frame buffer and shifts the
// resulting 32-bit frame out MSB-first, one bit per t_clk edge. The top nibble
// of the first byte is replaced by the 4'b1010 sync header. The frame buffer
// and the shift register are independent, so the next frame fills while the
// current one is on the line and can follow it without an idle bit.
// Optional build macro SERIALIZER_IDLE_GAP_EN: inserts exactly two idle (0)
// cycles after every frame before the next one may start.
module serializer (
    input  logic        t_clk,
    input  logic        rst_n,
    serializer_if.slave bus
);

    localparam int         BYTES    = 4;
    localparam logic [3:0] SYNC_HDR = 4'b1010;
    localparam logic [2:0] FULL     = 3'd4;
    localparam logic [4:0] LAST_IDX = 5'd31;

`ifdef SERIALIZER_IDLE_GAP_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        data_out_q, data_out_d;
`ifdef SERIALIZER_IDLE_GAP_EN
    logic        gap_cnt_q, gap_cnt_d;
`endif

    logic        accept;
    logic        frame_full;
    logic        load;
    logic [31:0] frame_word;

    // A byte is taken whenever the buffer has room; a full buffer stalls the
    // producer until the shifter takes the frame.
    assign accept     = bus.data_valid && (count_q < FULL);
    assign frame_full = (count_q == FULL);

    // ------------------------------------------------------------------
    // Frame buffer: one register per byte slot, written in arrival order.
    // Slot 0 stores the header-substituted byte so the assembled word is
    // ready to load as-is.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_slot
            logic [7:0] slot_q;
            logic [7:0] slot_in;

            if (gi == 0) begin : g_hdr
                assign slot_in = {SYNC_HDR, bus.data_in[3:0]};
            end else begin : g_plain
                assign slot_in = bus.data_in;
            end

            // Capture the incoming byte into the slot selected by the fill count.
            always_ff @(posedge t_clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_q <= '0;
                end else if (accept && (count_q == 3'(gi))) begin
                    slot_q <= slot_in;
                end
            end

            // Byte 0 occupies the most significant position of the frame.
            assign frame_word[31 - 8*gi -: 8] = slot_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic for the line FSM, shifter and fill count.
    // ------------------------------------------------------------------

    // Decide line activity for the coming edge and whether the buffer loads.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        data_out_d = data_out_q;
        load       = 1'b0;
`ifdef SERIALIZER_IDLE_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                data_out_d = 1'b0;
                if (frame_full) begin
                    load = 1'b1;
                end
            end

            SHIFT: begin
                if (bit_cnt_q != 5'd0) begin
                    // shift_q holds the bits still to be sent, next one on top.
                    data_out_d = shift_q[31];
                    shift_d    = {shift_q[30:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q - 5'd1;
                end else begin
`ifdef SERIALIZER_IDLE_GAP_EN
                    // Bit 0 is on the line: always follow with the idle gap.
                    state_d    = GAP;
                    gap_cnt_d  = 1'b0;
                    data_out_d = 1'b0;
`else
                    // Bit 0 is on the line: chain straight into a waiting frame.
                    if (frame_full) begin
                        load = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        data_out_d = 1'b0;
                    end
`endif
                end
            end

`ifdef SERIALIZER_IDLE_GAP_EN
            GAP: begin
                data_out_d = 1'b0;
                if (!gap_cnt_q) begin
                    gap_cnt_d = 1'b1;
                end else if (frame_full) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
`endif

            default: begin
                state_d    = IDLE;
                data_out_d = 1'b0;
            end
        endcase

        // Loading puts bit 31 on the line at the same edge; the shifter keeps
        // the remaining 31 bits left-aligned.
        if (load) begin
            state_d    = SHIFT;
            data_out_d = frame_word[31];
            shift_d    = {frame_word[30:0], 1'b0};
            bit_cnt_d  = LAST_IDX;
        end
    end

    // Fill count: cleared by a load, advanced by an accept (never both).
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = 3'd0;
        end else if (accept) begin
            count_d = count_q + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------

    // Register line state; reset forces the line low and the buffer empty.
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= 3'd0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            data_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            data_out_q <= data_out_d;
        end
    end

`ifdef SERIALIZER_IDLE_GAP_EN
    // Track which of the two idle-gap cycles is on the line.
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_q <= 1'b0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs, all derived from registered state.
    // ------------------------------------------------------------------
    assign bus.data_ready = (count_q < FULL);
    assign bus.data_out   = data_out_q;
    assign bus.busy       = (state_q == SHIFT);
    assign bus.frame_done = (state_q == SHIFT) && (bit_cnt_q == 5'd0);

endmodule

// File: tb/tb_serializer.sv
`timescale 1ns/1ps
// tb_serializer: directed scenarios plus randomized traffic, checked every
// cycle against a frame-scheduling reference model (bytes queued, frames
// timed by arithmetic on edge numbers).
module tb_serializer;

`ifdef SERIALIZER_IDLE_GAP_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 0;
`endif

    logic t_clk = 1'b0;
    logic rst_n = 1'b1;

    serializer_if bus ();

    serializer dut (
        .t_clk (t_clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 t_clk = ~t_clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model state.
    int          k = 0;              // edges elapsed
    logic [7:0]  m_buf[$];           // accepted bytes not yet framed
    bit          m_pending = 1'b0;   // a full frame waits for the line
    int          m_load_edge = 0;    // edge at which it goes on the line
    int          m_line_free = 0;    // first edge the line can start a frame
    logic [31:0] cur_frame = '0;
    int          cur_start = -1000;  // edge after which bit 31 is on the line
    bit          m_last_acc = 1'b0;

    // Observations.
    logic [31:0] rx_word = '0;
    logic [31:0] rx_frames[$];
    int          done_k[$];
    int          ready_low_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        logic [31:0] none;
        none = 'x;
        if (i < rx_frames.size()) return rx_frames[i];
        return none;
    endfunction

    task automatic model_reset();
        m_buf.delete();
        m_pending   = 1'b0;
        m_line_free = 0;
        cur_start   = -1000;
        rx_frames.delete();
        done_k.delete();
    endtask

    // Advance the model by one edge with the inputs present before that edge.
    task automatic model_edge(input bit v, input logic [7:0] d);
        bit acc;
        logic [7:0] b0, b1, b2, b3;
        k++;
        acc = v && (m_buf.size() < 4);
        m_last_acc = acc;
        if (m_pending && k == m_load_edge) begin
            b0 = m_buf[0]; b1 = m_buf[1]; b2 = m_buf[2]; b3 = m_buf[3];
            cur_frame   = {4'b1010, b0[3:0], b1, b2, b3};
            cur_start   = k;
            m_line_free = k + 32 + GAP;
            m_buf.delete();
            m_pending = 1'b0;
        end
        if (acc) begin
            m_buf.push_back(d);
            if (m_buf.size() == 4) begin
                m_pending   = 1'b1;
                m_load_edge = (k + 1 > m_line_free) ? k + 1 : m_line_free;
            end
        end
    endtask

    task automatic check_outputs();
        bit   inf;
        logic eo;
        inf = (k >= cur_start) && (k <= cur_start + 31);
        eo  = inf ? cur_frame[31 - (k - cur_start)] : 1'b0;
        chk("data_out",   {31'b0, bus.data_out},   {31'b0, eo});
        chk("busy",       {31'b0, bus.busy},       {31'b0, inf});
        chk("frame_done", {31'b0, bus.frame_done}, {31'b0, inf && (k == cur_start + 31)});
        chk("data_ready", {31'b0, bus.data_ready}, {31'b0, m_buf.size() < 4});
        if (!bus.data_ready) ready_low_cnt++;
        if (bus.busy) rx_word = {rx_word[30:0], bus.data_out};
        if (bus.frame_done) begin
            rx_frames.push_back(rx_word);
            done_k.push_back(k);
            $display("frame %h done at edge %0d", rx_word, k);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d);
        bus.data_valid = v;
        bus.data_in    = d;
        @(posedge t_clk);
        model_edge(v, d);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'($urandom));
    endtask

    // Hold the byte with valid high until it is taken (bounded).
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300; t++) begin
            step(1'b1, b);
            if (m_last_acc) begin
                done = 1'b1;
                break;
            end
        end
        chk("send_accept", {31'b0, done}, 32'd1);
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        send_byte(a); send_byte(b); send_byte(c); send_byte(d);
    endtask

    // Asynchronous reset between edges; outputs must clear before any edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_data_out",   {31'b0, bus.data_out},   32'd0);
        chk("rst_busy",       {31'b0, bus.busy},       32'd0);
        chk("rst_frame_done", {31'b0, bus.frame_done}, 32'd0);
        chk("rst_data_ready", {31'b0, bus.data_ready}, 32'd1);
        model_reset();
        @(posedge t_clk);
        k++;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_obs();
        rx_frames.delete();
        done_k.delete();
    endtask

    initial begin
        int found;
        int dens;
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        #1;
        do_reset();

        // Basic frame with header substitution.
        send4(8'h5A, 8'h12, 8'h34, 8'h56);
        idle(40);
        chk("f1_count", rx_frames.size(), 32'd1);
        chk("f1_word",  rx_at(0), 32'hAA123456);
        clear_obs();

        // Frame whose header nibble already matches.
        send4(8'hA1, 8'h12, 8'h34, 8'h56);
        idle(40);
        chk("f2_word", rx_at(0), 32'hA1123456);
        clear_obs();

        // Two frames supplied continuously.
        ready_low_cnt = 0;
        send4(8'h5F, 8'h01, 8'h02, 8'h03);
        send4(8'hAF, 8'h04, 8'h05, 8'h06);
        chk("b2b_ready_dropped", {31'b0, ready_low_cnt > 0}, 32'd1);
        idle(80);
        chk("b2b_count", rx_frames.size(), 32'd2);
        chk("b2b_word0", rx_at(0), 32'hAF010203);
        chk("b2b_word1", rx_at(1), 32'hAF040506);
        chk("b2b_spacing", (done_k.size() >= 2) ? done_k[1] - done_k[0] : -1, 32 + GAP);
        clear_obs();

        // Reset in the middle of a frame.
        send4(8'hC5, 8'h11, 8'h22, 8'h33);
        found = 0;
        for (int t = 0; t < 100; t++) begin
            if (k == cur_start + 13) begin
                found = 1;
                break;
            end
            step(1'b0, 8'($urandom));
        end
        chk("midframe_reached", found, 32'd1);
        do_reset();
        idle(10);
        send4(8'hA0, 8'hFF, 8'hFF, 8'hFF);
        idle(40);
        chk("post_rst_count", rx_frames.size(), 32'd1);
        chk("post_rst_word",  rx_at(0), 32'hA0FFFFFF);
        clear_obs();

        // Partial buffer waits indefinitely.
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
        idle(100);
        chk("stall_no_frame", rx_frames.size(), 32'd0);
        send_byte(8'h00);
        idle(40);
        chk("stall_word", rx_at(0), 32'hABCDEF00);
        clear_obs();

        // Randomized traffic with varying density and occasional resets.
        for (int seg = 0; seg < 6; seg++) begin
            dens = $urandom_range(1, 4);
            for (int t = 0; t < 500; t++) begin
                if ($urandom_range(0, 699) == 0) begin
                    do_reset();
                end else begin
                    step($urandom_range(0, 3) < dens, 8'($urandom));
                end
            end
        end
        idle(50);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 t_clk  input  1  serial bit clock; all state advances on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 data_in  input  8  parallel byte to transmit.
REQ-004 data_valid  input  1  data_in holds a valid byte this cycle.
REQ-005 data_ready  output  1  block accepts data_in this cycle; a transfer occurs on any edge where data_valid && data_ready.
REQ-006 data_out  output  1  registered serial line, MSB-first; idle level 0.
REQ-007 busy  output  1  a frame is being shifted onto data_out.
REQ-008 frame_done  output  1  one-cycle pulse while data_out carries the last bit of a frame.

Function
REQ-009 A frame SHALL be 32 bits: {byte0, byte1, byte2, byte3}, sent bit 31 first. byte0[7:4] is forced to 4'b1010 as the sync header, and byte0[3:0] plus byte1..byte3 form the 28-bit payload.
REQ-010 Accepted bytes SHALL be collected in order into a 4-byte frame buffer with a 3-bit fill count (0..4); data_ready = (count < 4).
REQ-011 A 32-bit shift register with a 5-bit bit counter SHALL drive data_out; the frame buffer and the shift register give double buffering, so the next frame can be collected while the current one shifts.
REQ-012 States: IDLE (data_out=0, busy=0), SHIFT (busy=1, one bit per cycle), GAP (only when configured, see REQ-022).
REQ-013 IDLE->SHIFT on the edge where count==4. At that edge: shift register <- buffer with header applied; data_out <- 1 (bit 31); count <- 0.
REQ-014 Latency: byte3 accepted at edge N with the shifter idle -> bit 31 on data_out after edge N+1; the last bit appears after edge N+32.
REQ-015 SHIFT: each edge outputs the next bit. frame_done=1 in the cycle that bit 0 is on data_out.
REQ-016 End of frame, without gap configuration: if count==4 at the edge after bit 0, load the next frame at that edge (back-to-back, no idle bit). Otherwise data_out <- 0 and go to IDLE.
REQ-017 Simultaneous load and accept cannot occur, because data_ready=0 whenever count==4. data_ready returns to 1 in the cycle after the load edge.
REQ-018 data_in/data_valid changes while data_ready=0 SHALL be ignored, with no loss or duplication of buffered bytes.
REQ-019 A partial buffer (count 1..3) SHALL wait indefinitely; no timeout, and no padding is inserted.

Reset
REQ-020 On rst_n low, immediately and regardless of clock: data_out=0, busy=0, frame_done=0, data_ready=1 (count=0), shift register, buffer and bit counter cleared, state IDLE.
REQ-021 Reset mid-frame SHALL abort the frame and drop partial buffer contents; after release, the line stays 0 until a new complete 4-byte frame is accepted.

Configuration
REQ-022 Macro SERIALIZER_IDLE_GAP_EN.
- Defined: after bit 0 of every frame, enter GAP and drive exactly 2 cycles of data_out=0 with busy=0. Then load the next frame if count==4, else go to IDLE.
- Not defined: GAP state absent; back-to-back per REQ-016.
- Byte acceptance is the same in both builds.

Verification
REQ-023 Reset, then bytes 0x5A,0x12,0x34,0x56 with data_valid held high -> data_out serial 0xAA123456 MSB-first starting one edge after byte3 is accepted; frame_done pulses once, on the 32nd bit.
REQ-024 Loopback data_out into the team deserializer's data_in, sending 0xA1,0x12,0x34,0x56 -> deserializer byte output sequence 0xA1,0x12,0x34,0x56.
REQ-025 Eight bytes 0x5F,0x01,0x02,0x03,0xAF,0x04,0x05,0x06 supplied continuously:
- data_ready drops after the 4th byte of the second frame while the first frame is shifting.
- Without the macro: 64 contiguous bits 0xAF010203,0xAF040506 with no idle bit.
- With SERIALIZER_IDLE_GAP_EN: exactly two 0 bits between the frames.
REQ-026 Assert rst_n low at bit 13 of a frame -> data_out=0 and busy=0 immediately; the next 4 bytes 0xA0,0xFF,0xFF,0xFF produce a clean frame 0xA0FFFFFF.
REQ-027 Send 3 bytes then stall 100 cycles -> data_out stays 0 and data_ready stays 1. The 4th byte 0x00 after bytes 0xAB,0xCD,0xEF gives frame 0xABCDEF00.
